decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 111 +++++++++++
 rtl/decode_logic.sv | 149 ++++++++++++++
 rtl/decode_stage.sv | 124 ++++++++++++
 tb/tb_decode_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU/CSR codes, mux selects, cause codes and the control word.
// Zicsr decoding in decode_logic is enabled by the DECODE_ZICSR_EN macro.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // CSR codes line up with funct3[1:0] of the CSR instructions.
  localparam logic [1:0] CSR_NONE = 2'd0;
  localparam logic [1:0] CSR_RW   = 2'd1;
  localparam logic [1:0] CSR_RS   = 2'd2;
  localparam logic [1:0] CSR_RC   = 2'd3;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;
  localparam logic [1:0] OP1_ZIMM = 2'd3;

  localparam logic [2:0] OP2_RS2   = 3'd0;
  localparam logic [2:0] OP2_IMM_I = 3'd1;
  localparam logic [2:0] OP2_IMM_S = 3'd2;
  localparam logic [2:0] OP2_IMM_U = 3'd3;
  localparam logic [2:0] OP2_IMM_J = 3'd4;

  localparam logic [1:0] BJ_NONE = 2'd0;
  localparam logic [1:0] BJ_BR   = 2'd1;
  localparam logic [1:0] BJ_JAL  = 2'd2;
  localparam logic [1:0] BJ_JALR = 2'd3;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_CSR = 3'd3;
  localparam logic [2:0] WB_MD  = 3'd4;

  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

  typedef struct packed {
    logic [3:0] alu_fn;
    logic [2:0] md_fn;
    logic [1:0] op1_sel;
    logic [2:0] op2_sel;
    logic [1:0] bj;
    logic [1:0] mem_len;
    logic       mem_ren;
    logic       mem_wen;
    logic       wb_sign;
    logic [2:0] wb_mux;
    logic [1:0] csr_fn;
    logic       rf_wen;
    logic       csr_wen;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
    logic [3:0]  cause;
    logic        mret;
  } entry_t;

  // alt selects SUB over ADD and SRA over SRL.
  function automatic logic [3:0] alu_fn_of(input logic [2:0] funct3, input logic alt);
    logic [3:0] fn;
    case (funct3)
      3'b000:  fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  fn = ALU_SLL;
      3'b010:  fn = ALU_SLT;
      3'b011:  fn = ALU_SLTU;
      3'b100:  fn = ALU_XOR;
      3'b101:  fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  fn = ALU_OR;
      default: fn = ALU_AND;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I(+M) instruction decoder producing the control word and exception info.
// Define DECODE_ZICSR_EN to decode the CSR instructions; otherwise they are illegal.
module decode_logic
  import decode_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        exc,
  output logic [3:0]  exc_cause,
  output logic        mret
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrl_t      base;
  logic       illegal;
  logic       is_ecall;
  logic       is_ebreak;
  logic       is_mret;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    base      = '0;
    illegal   = 1'b0;
    is_ecall  = 1'b0;
    is_ebreak = 1'b0;
    is_mret   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        base.op1_sel = OP1_ZERO;
        base.op2_sel = OP2_IMM_U;
        base.rf_wen  = 1'b1;
      end
      OPC_AUIPC: begin
        base.op1_sel = OP1_PC;
        base.op2_sel = OP2_IMM_U;
        base.rf_wen  = 1'b1;
      end
      OPC_JAL: begin
        base.op1_sel = OP1_PC;
        base.op2_sel = OP2_IMM_J;
        base.bj      = BJ_JAL;
        base.wb_mux  = WB_PC4;
        base.rf_wen  = 1'b1;
      end
      OPC_JALR: begin
        base.op2_sel = OP2_IMM_I;
        base.bj      = BJ_JALR;
        base.wb_mux  = WB_PC4;
        base.rf_wen  = 1'b1;
        illegal      = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        base.bj = BJ_BR;
        case (funct3[2:1])
          2'b00:   base.alu_fn = ALU_SUB;
          2'b10:   base.alu_fn = ALU_SLT;
          2'b11:   base.alu_fn = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        base.op2_sel = OP2_IMM_I;
        base.mem_ren = 1'b1;
        base.mem_len = funct3[1:0];
        base.wb_sign = !funct3[2];
        base.wb_mux  = WB_MEM;
        base.rf_wen  = 1'b1;
        illegal      = (funct3[1:0] == 2'b11) || (funct3[2] && funct3[1]);
      end
      OPC_STORE: begin
        base.op2_sel = OP2_IMM_S;
        base.mem_wen = 1'b1;
        base.mem_len = funct3[1:0];
        illegal      = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_IMM: begin
        base.op2_sel = OP2_IMM_I;
        base.alu_fn  = alu_fn_of(funct3, (funct3 == 3'b101) && funct7[5]);
        base.rf_wen  = 1'b1;
        if (funct3 == 3'b001)
          illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_REG: begin
        base.rf_wen = 1'b1;
        if (funct7 == 7'b0000000)
          base.alu_fn = alu_fn_of(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          base.alu_fn = alu_fn_of(funct3, 1'b1);
        else if (funct7 == 7'b0000001 && M_EXT != 0) begin
          base.md_fn  = funct3;
          base.wb_mux = WB_MD;
        end else
          illegal = 1'b1;
      end
      OPC_FENCE: begin
        // Single-hart in-order pipeline: FENCE decodes as a no-op.
      end
      OPC_SYSTEM: begin
        if (instr == INSTR_ECALL)
          is_ecall = 1'b1;
        else if (instr == INSTR_EBREAK)
          is_ebreak = 1'b1;
        else if (instr == INSTR_MRET)
          is_mret = 1'b1;
`ifdef DECODE_ZICSR_EN
        else if (funct3 != 3'b000 && funct3 != 3'b100) begin
          base.csr_fn  = funct3[1:0];
          base.op1_sel = funct3[2] ? OP1_ZIMM : OP1_RS1;
          base.wb_mux  = WB_CSR;
          base.rf_wen  = 1'b1;
          base.csr_wen = 1'b1;
        end
`endif
        else
          illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    ctrl      = base;
    exc       = illegal || is_ecall || is_ebreak;
    exc_cause = '0;
    mret      = is_mret;
    if (illegal)
      exc_cause = CAUSE_ILLEGAL;
    else if (is_ebreak)
      exc_cause = CAUSE_BREAKPOINT;
    else if (is_ecall)
      exc_cause = CAUSE_ECALL_M;
    // An excepting instruction must not leave any architectural side effect.
    if (exc) begin
      ctrl.rf_wen  = 1'b0;
      ctrl.csr_wen = 1'b0;
      ctrl.mem_wen = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decoder plus a DEPTH-entry FIFO of decoded entries and an illegal-instruction counter.
// CSR decoding follows the DECODE_ZICSR_EN macro inside decode_logic.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int M_EXT = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [31:0]       pc_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic              exc_o,
  output logic [3:0]        exc_cause_o,
  output logic              mret_o,
  output logic [CNT_W-1:0]  illegal_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  ctrl_t            dec_ctrl;
  logic             dec_exc;
  logic [3:0]       dec_cause;
  logic             dec_mret;
  entry_t           push_entry;
  entry_t           head_entry;
  entry_t           mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic [CNT_W-1:0] illegal_cnt_reg, illegal_cnt_next;
  logic             full, empty, push, pop, push_keep;

  decode_logic #(.M_EXT(M_EXT)) u_decode_logic (
    .instr     (instr_i),
    .ctrl      (dec_ctrl),
    .exc       (dec_exc),
    .exc_cause (dec_cause),
    .mret      (dec_mret)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  assign full          = (occ_reg == FULL_OCC);
  assign empty         = (occ_reg == '0);
  assign instr_ready_o = !full;
  assign push          = instr_valid_i && !full;
  assign pop           = !empty && dec_ready_i;
  // A push coinciding with a flush is dropped and never counted.
  assign push_keep     = push && !flush_i;
  assign push_entry    = '{ctrl: dec_ctrl, instr: instr_i, pc: pc_i,
                           exc: dec_exc, cause: dec_cause, mret: dec_mret};

  always_comb begin
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    occ_next         = occ_reg;
    illegal_cnt_next = illegal_cnt_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      occ_next    = '0;
    end else begin
      if (push)
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   occ_next = occ_reg + OCC_W'(1);
        2'b01:   occ_next = occ_reg - OCC_W'(1);
        default: occ_next = occ_reg;
      endcase
    end
    if (push_keep && dec_exc && dec_cause == CAUSE_ILLEGAL && illegal_cnt_reg != '1)
      illegal_cnt_next = illegal_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      occ_reg         <= '0;
      illegal_cnt_reg <= '0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      occ_reg         <= occ_next;
      illegal_cnt_reg <= illegal_cnt_next;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk_i) begin
      if (push_keep && wr_ptr_reg == PTR_W'(gi))
        mem_reg[gi] <= push_entry;
    end
  end

  assign head_entry    = empty ? '0 : mem_reg[rd_ptr_reg];
  assign dec_valid_o   = !empty;
  assign ctrl_o        = head_entry.ctrl;
  assign instr_o       = head_entry.instr;
  assign pc_o          = head_entry.pc;
  assign exc_o         = head_entry.exc;
  assign exc_cause_o   = head_entry.cause;
  assign mret_o        = head_entry.mret;
  assign illegal_cnt_o = illegal_cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an M_EXT=1 and an M_EXT=0 instance share one stimulus stream.
module tb_decode_stage;
  import decode_pkg::*;

  localparam logic [31:0] I_ADD   = 32'h0020_81B3;
  localparam logic [31:0] I_SUB   = 32'h4020_81B3;
  localparam logic [31:0] I_MUL   = 32'h0220_81B3;
  localparam logic [31:0] I_LW    = 32'h0040_A183;
  localparam logic [31:0] I_SW    = 32'h0020_A223;
  localparam logic [31:0] I_SBAD  = 32'h0020_B223;
  localparam logic [31:0] I_ZERO  = 32'h0000_0000;
  localparam logic [31:0] I_CSRRW = 32'h3052_9073;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush, instr_valid, dec_ready;
  logic [31:0] instr, pc;

  logic              ready_a, valid_a, exc_a, mret_a;
  logic [CTRL_W-1:0] ctrl_a;
  logic [31:0]       instr_a, pc_a;
  logic [3:0]        cause_a;
  logic [15:0]       cnt_a;
  logic              ready_b, valid_b, exc_b, mret_b;
  logic [CTRL_W-1:0] ctrl_b;
  logic [31:0]       instr_b, pc_b;
  logic [3:0]        cause_b;
  logic [15:0]       cnt_b;

  decode_stage #(.DEPTH(2), .M_EXT(1), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset_n), .flush_i(flush),
    .instr_valid_i(instr_valid), .instr_ready_o(ready_a), .instr_i(instr), .pc_i(pc),
    .dec_valid_o(valid_a), .dec_ready_i(dec_ready), .ctrl_o(ctrl_a), .instr_o(instr_a),
    .pc_o(pc_a), .exc_o(exc_a), .exc_cause_o(cause_a), .mret_o(mret_a), .illegal_cnt_o(cnt_a)
  );

  decode_stage #(.DEPTH(2), .M_EXT(0), .CNT_W(16)) dut_no_m (
    .clk_i(clk), .reset_i(reset_n), .flush_i(flush),
    .instr_valid_i(instr_valid), .instr_ready_o(ready_b), .instr_i(instr), .pc_i(pc),
    .dec_valid_o(valid_b), .dec_ready_i(dec_ready), .ctrl_o(ctrl_b), .instr_o(instr_b),
    .pc_o(pc_b), .exc_o(exc_b), .exc_cause_o(cause_b), .mret_o(mret_b), .illegal_cnt_o(cnt_b)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
    logic [3:0]  cause;
    logic        mret;
    logic        rf_wen;
    logic        csr_wen;
    logic        mem_wen;
    logic        chk_alu;
    logic [3:0]  alu_fn;
    logic        chk_wb;
    logic [2:0]  wb_mux;
    logic        exc_no_m;
    logic [3:0]  cause_no_m;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          model_cnt_a = 0;
  int          model_cnt_b = 0;
  logic [31:0] pc_next = 32'h100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Hand-written expectations for each instruction word used below.
  function automatic exp_t expect_of(input logic [31:0] w, input logic [31:0] a);
    exp_t e;
    e = '{default: '0};
    e.instr = w;
    e.pc    = a;
    case (w)
      I_ADD:  begin e.rf_wen = 1; e.chk_alu = 1; e.alu_fn = ALU_ADD; e.chk_wb = 1; e.wb_mux = WB_ALU; end
      I_SUB:  begin e.rf_wen = 1; e.chk_alu = 1; e.alu_fn = ALU_SUB; e.chk_wb = 1; e.wb_mux = WB_ALU; end
      I_MUL:  begin e.rf_wen = 1; e.chk_wb = 1; e.wb_mux = WB_MD; end
      I_LW:   begin e.rf_wen = 1; e.chk_alu = 1; e.alu_fn = ALU_ADD; e.chk_wb = 1; e.wb_mux = WB_MEM; end
      I_SW:   begin e.mem_wen = 1; e.chk_alu = 1; e.alu_fn = ALU_ADD; end
      I_SBAD: begin e.exc = 1; e.cause = 4'd2; end
      I_ZERO: begin e.exc = 1; e.cause = 4'd2; end
      32'h0000_0073: begin e.exc = 1; e.cause = 4'd11; end
      32'h0010_0073: begin e.exc = 1; e.cause = 4'd3; end
      32'h3020_0073: begin e.mret = 1; end
`ifdef DECODE_ZICSR_EN
      I_CSRRW: begin e.rf_wen = 1; e.csr_wen = 1; e.chk_wb = 1; e.wb_mux = WB_CSR; end
`else
      I_CSRRW: begin e.exc = 1; e.cause = 4'd2; end
`endif
      default: begin e.exc = 1; e.cause = 4'hF; end
    endcase
    if (w == I_MUL) begin
      e.exc_no_m   = 1'b1;
      e.cause_no_m = 4'd2;
    end else begin
      e.exc_no_m   = e.exc;
      e.cause_no_m = e.cause;
    end
    return e;
  endfunction

  // One clock: evaluate handshakes at the falling edge, then let the rising edge act.
  task automatic step();
    exp_t  e;
    ctrl_t c;
    @(negedge clk);
    check("illegal_cnt", cnt_a, 64'(model_cnt_a));
    check("illegal_cnt_no_m", cnt_b, 64'(model_cnt_b));
    check("valid_match", valid_b, valid_a);
    if (!valid_a)
      check("empty_zero", |{ctrl_a, instr_a, pc_a, exc_a, cause_a, mret_a}, 1'b0);
    if (valid_a && dec_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        c = ctrl_a;
        check("instr", instr_a, e.instr);
        check("pc", pc_a, e.pc);
        check("exc", exc_a, e.exc);
        check("cause", cause_a, e.cause);
        check("mret", mret_a, e.mret);
        check("rf_wen", c.rf_wen, e.rf_wen);
        check("csr_wen", c.csr_wen, e.csr_wen);
        check("mem_wen", c.mem_wen, e.mem_wen);
        if (e.chk_alu) check("alu_fn", c.alu_fn, e.alu_fn);
        if (e.chk_wb) check("wb_mux", c.wb_mux, e.wb_mux);
        check("exc_no_m", exc_b, e.exc_no_m);
        check("cause_no_m", cause_b, e.cause_no_m);
        $display("pop  instr=%08h pc=%08h exc=%0d cause=%0d mret=%0d", instr_a, pc_a, exc_a, cause_a, mret_a);
      end
    end
    if (instr_valid && ready_a && !flush) begin
      e = expect_of(instr, pc);
      sb.push_back(e);
      if (e.exc && e.cause == 4'd2) model_cnt_a++;
      if (e.exc_no_m && e.cause_no_m == 4'd2) model_cnt_b++;
      pc_next = pc + 32'd4;
      $display("push instr=%08h pc=%08h", instr, pc);
    end
    if (flush) begin
      sb.delete();
      $display("flush");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] w);
    instr_valid = 1'b1;
    instr       = w;
    pc          = pc_next;
    step();
    instr_valid = 1'b0;
  endtask

  logic [31:0] prog [11];

  initial begin
    prog = '{I_ADD, I_MUL, 32'h0000_0073, 32'h0010_0073, 32'h3020_0073, I_CSRRW,
             I_SW, I_LW, I_SUB, I_SBAD, I_ZERO};
    reset_n = 1'b0; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0;
    instr = '0; pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_a, 1'b0);
    check("rst_ready", ready_a, 1'b1);
    check("rst_cnt", cnt_a, 16'd0);
    check("rst_zero", |{ctrl_a, instr_a, pc_a, exc_a, cause_a, mret_a}, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD into an empty stage: visible right after the next edge.
    dec_ready = 1'b1;
    feed(I_ADD);
    check("add_latency", valid_a, 1'b1);
    step();

    // Back-to-back stream of the instruction table.
    foreach (prog[i]) feed(prog[i]);
    repeat (2) step();

    // Back-pressure: fill, hold a third offer, then a single pop.
    dec_ready = 1'b0;
    feed(I_ADD);
    feed(I_SUB);
    check("full_ready", ready_a, 1'b0);
    instr_valid = 1'b1; instr = I_LW; pc = pc_next;
    step();
    check("held_ready", ready_a, 1'b0);
    check("hold_head", instr_a, I_ADD);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check("ready_after_pop", ready_a, 1'b1);
    check("fifo_order", instr_a, I_SUB);
    step();
    instr_valid = 1'b0;
    dec_ready = 1'b1;
    repeat (3) step();

    // Flush with a full buffer and an offered illegal instruction.
    dec_ready = 1'b0;
    feed(I_ZERO);
    feed(I_SW);
    instr_valid = 1'b1; instr = I_SBAD; pc = pc_next; flush = 1'b1;
    step();
    flush = 1'b0; instr_valid = 1'b0;
    check("flush_valid", valid_a, 1'b0);
    check("flush_ready", ready_a, 1'b1);
    check("flush_cnt", cnt_a, 64'(model_cnt_a));

    // Flush with one entry while an illegal push is accepted by the handshake.
    feed(32'h0000_0073);
    instr_valid = 1'b1; instr = I_ZERO; pc = pc_next; flush = 1'b1;
    step();
    flush = 1'b0; instr_valid = 1'b0;
    check("flush2_valid", valid_a, 1'b0);
    check("flush2_cnt", cnt_a, 64'(model_cnt_a));

    // Asynchronous reset in the middle of traffic.
    feed(I_MUL);
    feed(I_ZERO);
    #2 reset_n = 1'b0;
    #1;
    sb.delete();
    model_cnt_a = 0;
    model_cnt_b = 0;
    check("mid_rst_valid", valid_a, 1'b0);
    check("mid_rst_ready", ready_a, 1'b1);
    check("mid_rst_cnt", cnt_a, 16'd0);
    check("mid_rst_cnt_no_m", cnt_b, 16'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    dec_ready = 1'b1;
    feed(32'h0010_0073);
    feed(I_ADD);
    repeat (2) step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
